// File: rtl/mii_tx_engine_if.sv
// rtl/mii_tx_engine_if.sv - read side of the per-port tx pointer/data FIFO pair
interface mii_tx_engine_if;
    logic        tx_ptr_fifo_empty;
    logic        tx_ptr_fifo_rd;
    logic [15:0] tx_ptr_fifo_dout;
    logic        tx_data_fifo_rd;
    logic [7:0]  tx_data_fifo_dout;

    modport master (
        input  tx_ptr_fifo_empty,
        input  tx_ptr_fifo_dout,
        input  tx_data_fifo_dout,
        output tx_ptr_fifo_rd,
        output tx_data_fifo_rd
    );

    modport slave (
        output tx_ptr_fifo_empty,
        output tx_ptr_fifo_dout,
        output tx_data_fifo_dout,
        input  tx_ptr_fifo_rd,
        input  tx_data_fifo_rd
    );
endinterface

// File: rtl/mii_tx_engine.sv
// rtl/mii_tx_engine.sv - MAC tx engine: descriptor/data FIFO to MII nibbles with IFG
// MII_TX_CRC_GEN_EN adds zero pad to MIN_FRAME and a CRC-32 FCS.
module mii_tx_engine #(
    parameter int IFG_NIBBLES = 24,
    parameter int MIN_FRAME   = 60,
    parameter int MAX_LEN     = 1518
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            tx_ce,
    mii_tx_engine_if.master fifo,
    output logic [3:0]      mii_txd,
    output logic            mii_tx_en,
    output logic            mii_tx_er,
    output logic            busy,
    output logic            frame_done,
    output logic            frame_drop
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PTR_WAIT = 3'd1,
        S_PREAMBLE = 3'd2,
        S_DATA     = 3'd3,
        S_IFG      = 3'd4,
`ifdef MII_TX_CRC_GEN_EN
        S_PAD      = 3'd6,
        S_FCS      = 3'd7,
`endif
        S_DROP     = 3'd5
    } state_t;

    localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);
    localparam logic [7:0]  IFG_LAST  = 8'(IFG_NIBBLES - 1);

    state_t      state_q, state_d;
    logic [10:0] len_q, len_d;
    logic [10:0] byte_cnt_q, byte_cnt_d;
    logic [7:0]  slot_q, slot_d;
    logic        phase_q, phase_d;
    logic [7:0]  hold_q, hold_d;
    logic [7:0]  cur_q, cur_d;
    logic        rd_dly_q, rd_dly_d;
    logic [3:0]  txd_q, txd_d;
    logic        tx_en_q, tx_en_d;
    logic        ptr_rd_q, ptr_rd_d;
    logic        data_rd_q, data_rd_d;
    logic        done_q, done_d;
    logic        drop_q, drop_d;

    logic [10:0] desc_len;
    logic        desc_ok;
    logic        last_byte;

    assign desc_len  = fifo.tx_ptr_fifo_dout[10:0];
    assign desc_ok   = (desc_len != 11'd0) && (desc_len <= MAX_LEN_L);
    assign last_byte = (byte_cnt_q == len_q - 11'd1);

`ifdef MII_TX_CRC_GEN_EN
    localparam logic [10:0] MIN_L = 11'(MIN_FRAME);

    logic [31:0] crc_q, crc_d;
    logic [31:0] fcs;

    assign fcs = ~crc_q;

    function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            r = (r >> 1) ^ (((r[0] ^ d[i]) != 1'b0) ? 32'hEDB8_8320 : 32'h0);
        end
        return r;
    endfunction
`else
    // descriptor top bits and the pad target have no function without CRC generation
    logic unused_ok;
    assign unused_ok = &{1'b0, fifo.tx_ptr_fifo_dout[15:11], 11'(MIN_FRAME)};
`endif

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            byte_cnt_q <= '0;
            slot_q     <= '0;
            phase_q    <= 1'b0;
            hold_q     <= '0;
            cur_q      <= '0;
            rd_dly_q   <= 1'b0;
            txd_q      <= '0;
            tx_en_q    <= 1'b0;
            ptr_rd_q   <= 1'b0;
            data_rd_q  <= 1'b0;
            done_q     <= 1'b0;
            drop_q     <= 1'b0;
`ifdef MII_TX_CRC_GEN_EN
            crc_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            byte_cnt_q <= byte_cnt_d;
            slot_q     <= slot_d;
            phase_q    <= phase_d;
            hold_q     <= hold_d;
            cur_q      <= cur_d;
            rd_dly_q   <= rd_dly_d;
            txd_q      <= txd_d;
            tx_en_q    <= tx_en_d;
            ptr_rd_q   <= ptr_rd_d;
            data_rd_q  <= data_rd_d;
            done_q     <= done_d;
            drop_q     <= drop_d;
`ifdef MII_TX_CRC_GEN_EN
            crc_q      <= crc_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (!fifo.tx_ptr_fifo_empty) state_d = S_PTR_WAIT;
            // the first PTR_WAIT clk covers the FIFO read latency
            S_PTR_WAIT: if (!ptr_rd_q) state_d = desc_ok ? S_PREAMBLE : S_DROP;
            S_PREAMBLE: if (tx_ce && slot_q == 8'd15) state_d = S_DATA;
            S_DATA: begin
                if (tx_ce && phase_q && last_byte) begin
`ifdef MII_TX_CRC_GEN_EN
                    state_d = (len_q < MIN_L) ? S_PAD : S_FCS;
`else
                    state_d = S_IFG;
`endif
                end
            end
`ifdef MII_TX_CRC_GEN_EN
            S_PAD:      if (tx_ce && phase_q && byte_cnt_q == MIN_L - 11'd1) state_d = S_FCS;
            S_FCS:      if (tx_ce && slot_q == 8'd7) state_d = S_IFG;
`endif
            S_IFG:      if (tx_ce && slot_q == IFG_LAST) state_d = S_IDLE;
            S_DROP:     if (byte_cnt_q == len_q) state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    always_comb begin
        len_d      = len_q;
        byte_cnt_d = byte_cnt_q;
        slot_d     = slot_q;
        phase_d    = phase_q;
        cur_d      = cur_q;
        txd_d      = txd_q;
        tx_en_d    = tx_en_q;
        ptr_rd_d   = 1'b0;
        data_rd_d  = 1'b0;
        done_d     = 1'b0;
        drop_d     = 1'b0;
        rd_dly_d   = data_rd_q;
        hold_d     = rd_dly_q ? fifo.tx_data_fifo_dout : hold_q;
`ifdef MII_TX_CRC_GEN_EN
        crc_d      = crc_q;
`endif
        case (state_q)
            S_IDLE: begin
                byte_cnt_d = '0;
                slot_d     = '0;
                phase_d    = 1'b0;
                if (!fifo.tx_ptr_fifo_empty) ptr_rd_d = 1'b1;
            end
            S_PTR_WAIT: begin
                if (!ptr_rd_q) begin
                    len_d      = desc_len;
                    byte_cnt_d = '0;
                    slot_d     = '0;
                    phase_d    = 1'b0;
                    data_rd_d  = desc_ok;
`ifdef MII_TX_CRC_GEN_EN
                    crc_d      = 32'hFFFF_FFFF;
`endif
                end
            end
            S_PREAMBLE: begin
                if (tx_ce) begin
                    tx_en_d = 1'b1;
                    txd_d   = (slot_q == 8'd15) ? 4'hD : 4'h5;
                    slot_d  = (slot_q == 8'd15) ? 8'd0 : slot_q + 8'd1;
                end
            end
            S_DATA: begin
                if (tx_ce) begin
                    tx_en_d = 1'b1;
                    if (!phase_q) begin
                        // snapshot the byte so the refill of hold_q cannot disturb the high nibble
                        txd_d   = hold_q[3:0];
                        cur_d   = hold_q;
                        phase_d = 1'b1;
                        if (byte_cnt_q + 11'd1 < len_q) data_rd_d = 1'b1;
                    end else begin
                        txd_d      = cur_q[7:4];
                        phase_d    = 1'b0;
                        byte_cnt_d = byte_cnt_q + 11'd1;
`ifdef MII_TX_CRC_GEN_EN
                        crc_d      = crc32_byte(crc_q, cur_q);
`endif
                    end
                end
            end
`ifdef MII_TX_CRC_GEN_EN
            S_PAD: begin
                if (tx_ce) begin
                    tx_en_d = 1'b1;
                    txd_d   = 4'h0;
                    phase_d = !phase_q;
                    if (phase_q) begin
                        byte_cnt_d = byte_cnt_q + 11'd1;
                        crc_d      = crc32_byte(crc_q, 8'h00);
                    end
                end
            end
            S_FCS: begin
                if (tx_ce) begin
                    tx_en_d = 1'b1;
                    txd_d   = fcs[{slot_q[2:0], 2'b00} +: 4];
                    slot_d  = (slot_q == 8'd7) ? 8'd0 : slot_q + 8'd1;
                end
            end
`endif
            S_IFG: begin
                if (tx_ce) begin
                    tx_en_d = 1'b0;
                    txd_d   = 4'h0;
                    if (slot_q == IFG_LAST) begin
                        done_d = 1'b1;
                        slot_d = '0;
                    end else begin
                        slot_d = slot_q + 8'd1;
                    end
                end
            end
            S_DROP: begin
                if (byte_cnt_q == len_q) begin
                    drop_d = 1'b1;
                end else if (tx_ce) begin
                    data_rd_d  = 1'b1;
                    byte_cnt_d = byte_cnt_q + 11'd1;
                end
            end
            default: ;
        endcase
    end

    assign fifo.tx_ptr_fifo_rd  = ptr_rd_q;
    assign fifo.tx_data_fifo_rd = data_rd_q;
    assign mii_txd              = txd_q;
    assign mii_tx_en            = tx_en_q;
    assign mii_tx_er            = 1'b0;
    assign busy                 = (state_q != S_IDLE);
    assign frame_done           = done_q;
    assign frame_drop           = drop_q;

endmodule

// File: tb/tb_mii_tx_engine.sv
// tb/tb_mii_tx_engine.sv - directed bench for mii_tx_engine with FIFO model and CRC reference
module tb_mii_tx_engine;

`ifdef MII_TX_CRC_GEN_EN
    localparam int E64 = 152;
    localparam int E10 = 144;
    localparam int E20 = 144;
`else
    localparam int E64 = 144;
    localparam int E10 = 36;
    localparam int E20 = 56;
`endif

    logic       clk = 1'b0;
    logic       rstn;
    logic       tx_ce = 1'b0;
    logic [3:0] mii_txd;
    logic       mii_tx_en;
    logic       mii_tx_er;
    logic       busy;
    logic       frame_done;
    logic       frame_drop;
    logic [1:0] ce_div = 2'd0;

    always #5 clk = ~clk;

    mii_tx_engine_if tif();

    mii_tx_engine dut (
        .clk        (clk),
        .rstn       (rstn),
        .tx_ce      (tx_ce),
        .fifo       (tif),
        .mii_txd    (mii_txd),
        .mii_tx_en  (mii_tx_en),
        .mii_tx_er  (mii_tx_er),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_drop (frame_drop)
    );

    logic [15:0] ptr_q[$];
    logic [7:0]  data_q[$];
    logic [7:0]  exp_bytes[$];
    logic [4:0]  slots[$];
    logic [3:0]  en[$];
    int          done_slots[$];
    int          ptr_rd_slots[$];
    int done_cnt, drop_cnt, data_rd_cnt, ptr_rd_cnt, er_cnt, en_cnt;
    int n_checks = 0;
    int n_errors = 0;

    always @(posedge clk) begin
        if (tif.tx_ptr_fifo_rd && ptr_q.size() > 0) tif.tx_ptr_fifo_dout <= ptr_q.pop_front();
        if (tif.tx_data_fifo_rd && data_q.size() > 0) tif.tx_data_fifo_dout <= data_q.pop_front();
    end

    // sample outputs mid-cycle, then advance tx_ce (one slot every 4 clk)
    always @(negedge clk) begin
        if (tx_ce) begin
            slots.push_back({mii_tx_en, mii_txd});
            if (mii_tx_en) en_cnt++;
        end
        if (frame_done) begin
            done_cnt++;
            done_slots.push_back(slots.size());
        end
        if (frame_drop) drop_cnt++;
        if (tif.tx_data_fifo_rd) data_rd_cnt++;
        if (tif.tx_ptr_fifo_rd) begin
            ptr_rd_cnt++;
            ptr_rd_slots.push_back(slots.size());
        end
        if (mii_tx_er) er_cnt++;
        tif.tx_ptr_fifo_empty = (ptr_q.size() == 0);
        tx_ce  = (ce_div == 2'd3);
        ce_div = ce_div + 2'd1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c ^ {24'h0, d};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB8_8320) : (r >> 1);
        return r;
    endfunction

    function automatic logic [3:0] nib(input int i);
        return (i < en.size()) ? en[i] : 4'h0;
    endfunction

    task automatic clear_log();
        @(posedge clk);
        #1;
        slots.delete();
        done_slots.delete();
        ptr_rd_slots.delete();
        exp_bytes.delete();
        done_cnt = 0; drop_cnt = 0; data_rd_cnt = 0;
        ptr_rd_cnt = 0; er_cnt = 0; en_cnt = 0;
    endtask

    task automatic push_frame(input int len, input int seed);
        for (int i = 0; i < len; i++) begin
            data_q.push_back(8'(i * 37 + seed));
            exp_bytes.push_back(8'(i * 37 + seed));
        end
        ptr_q.push_back({5'h15, 11'(len)});
    endtask

    task automatic wait_events(input string tag, input int target, input int budget);
        int n = 0;
        while (done_cnt + drop_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_complete"}, done_cnt + drop_cnt, target);
        repeat (8) @(negedge clk);
    endtask

    task automatic check_frame(input string tag, input int len, input int exp_en);
        int last_en, errs, nbytes, idle;
        logic [31:0] c, got;
        logic [7:0]  b;
        en.delete();
        last_en = -1;
        for (int i = 0; i < slots.size(); i++) begin
            if (slots[i][4]) begin
                en.push_back(slots[i][3:0]);
                last_en = i;
            end
        end
        check({tag, "_en_nibbles"}, en.size(), exp_en);
        errs = 0;
        for (int i = 0; i < 16; i++) if (nib(i) != ((i == 15) ? 4'hD : 4'h5)) errs++;
        check({tag, "_preamble_errs"}, errs, 0);
        nbytes = len;
`ifdef MII_TX_CRC_GEN_EN
        if (nbytes < 60) nbytes = 60;
`endif
        errs = 0;
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < nbytes; i++) begin
            b = (i < len) ? exp_bytes[i] : 8'h00;
            c = crc_step(c, b);
            if ({nib(17 + 2 * i), nib(16 + 2 * i)} != b) errs++;
        end
        check({tag, "_payload_errs"}, errs, 0);
`ifdef MII_TX_CRC_GEN_EN
        got = 32'h0;
        for (int k = 0; k < 8; k++) got = got | (32'(nib(16 + 2 * nbytes + k)) << (4 * k));
        check({tag, "_fcs"}, got, ~c);
`endif
        check({tag, "_data_rd"}, data_rd_cnt, len);
        check({tag, "_done_cnt"}, done_cnt, 1);
        idle = (done_slots.size() > 0) ? done_slots[0] - (last_en + 1) : -1;
        check({tag, "_ifg_slots"}, idle, 24);
        check({tag, "_tx_er"}, er_cnt, 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        string       s;
        logic [31:0] c;
        int          n, last_a, first_b;

        rstn = 1'b0;
        repeat (6) @(negedge clk);
        check("reset_outputs",
              {busy, mii_tx_en, mii_txd, tif.tx_ptr_fifo_rd, tif.tx_data_fifo_rd,
               frame_done, frame_drop, mii_tx_er}, 32'h0);
        rstn = 1'b1;

        s = "123456789";
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < s.len(); i++) c = crc_step(c, s[i]);
        check("crc_model", ~c, 32'hCBF4_3926);

        clear_log();
        push_frame(64, 5);
        wait_events("len64", 1, 3000);
        check_frame("len64", 64, E64);

        clear_log();
        push_frame(10, 17);
        wait_events("len10", 1, 3000);
        check_frame("len10", 10, E10);

        clear_log();
        ptr_q.push_back({5'h1f, 11'd0});
        wait_events("drop0", 1, 500);
        check("drop0_cnt", drop_cnt, 1);
        check("drop0_data_rd", data_rd_cnt, 0);
        check("drop0_tx_en", en_cnt, 0);

        clear_log();
        for (int i = 0; i < 1600; i++) data_q.push_back(8'(i));
        ptr_q.push_back(16'd1600);
        wait_events("drop1600", 1, 10000);
        check("drop1600_cnt", drop_cnt, 1);
        check("drop1600_data_rd", data_rd_cnt, 1600);
        check("drop1600_tx_en", en_cnt, 0);
        check("drop1600_done", done_cnt, 0);
        check("drop1600_left", data_q.size(), 0);

        clear_log();
        push_frame(20, 3);
        push_frame(20, 9);
        wait_events("b2b", 2, 4000);
        check("b2b_ptr_rd", ptr_rd_cnt, 2);
        check("b2b_tx_en", en_cnt, 2 * E20);
        if (done_slots.size() > 0 && ptr_rd_slots.size() > 1) begin
            check("b2b_pop_after_ifg", 32'(ptr_rd_slots[1] >= done_slots[0]), 1);
            last_a  = -1;
            first_b = -1;
            for (int i = 0; i < slots.size(); i++) begin
                if (slots[i][4] && i < done_slots[0]) last_a = i;
                if (slots[i][4] && i >= done_slots[0] && first_b < 0) first_b = i;
            end
            check("b2b_gap", first_b - last_a - 1, 24);
        end else begin
            check("b2b_events", done_slots.size() + ptr_rd_slots.size(), 3);
        end

        clear_log();
        push_frame(64, 1);
        n = 0;
        while (en_cnt < 57 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("rst_reached_byte20", 32'(en_cnt >= 57), 1);
        rstn = 1'b0;
        @(negedge clk);
        check("rst_mid_outputs",
              {mii_tx_en, busy, tif.tx_ptr_fifo_rd, tif.tx_data_fifo_rd, mii_txd}, 32'h0);
        rstn = 1'b1;
        data_q.delete();
        repeat (4) @(negedge clk);

        clear_log();
        push_frame(10, 64);
        wait_events("after_rst", 1, 3000);
        check_frame("after_rst", 10, E10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/mii_tx_engine.md
Name: mii_tx_engine

Overview:
- MAC transmit engine for one switch egress port.
- Pops a frame descriptor from the port's tx pointer FIFO, then the frame bytes from the tx data FIFO.
- Serialises the frame onto MII as nibbles: preamble/SFD, payload, optional pad + FCS, then enforced inter-frame gap.
- Consumer end of the per-port tx ptr/data FIFO pair filled by the switch fabric; one instance per MAC.

Parameters:
- IFG_NIBBLES, 24, idle nibble slots after each frame (12 byte times).
- MIN_FRAME, 60, minimum bytes before FCS; pad target when CRC generation is compiled in.
- MAX_LEN, 1518, largest legal descriptor length in bytes.

Ports:
- clk  input  1  system clock, all logic rising edge.
- rstn  input  1  synchronous active-low reset.
- tx_ce  input  1  nibble strobe, one clk pulse per MII nibble slot; consecutive pulses at least 2 clk apart.
- tx_ptr_fifo_empty  input  1  descriptor FIFO empty.
- tx_ptr_fifo_rd  output  1  descriptor pop, single-clk pulse.
- tx_ptr_fifo_dout  input  16  descriptor: [10:0] byte length, [15:11] ignored.
- tx_data_fifo_rd  output  1  data byte pop, single-clk pulse.
- tx_data_fifo_dout  input  8  frame byte.
- mii_txd  output  4  transmit nibble.
- mii_tx_en  output  1  transmit enable.
- mii_tx_er  output  1  transmit error, constant 0.
- busy  output  1  high in every state except IDLE.
- frame_done  output  1  one-clk pulse when IFG completes.
- frame_drop  output  1  one-clk pulse when an illegal descriptor finishes discard.

Behaviour:
- Both FIFOs are standard-read: dout is valid on the clk after the rd pulse.
- Reset values: all outputs 0; state IDLE; counters 0.
- Outputs change only on clk edges where tx_ce=1, except rd pulses and status pulses.
- IDLE: if !tx_ptr_fifo_empty, pulse tx_ptr_fifo_rd and go to PTR_WAIT.
- PTR_WAIT: latch len = dout[10:0].
  - len==0 or len>MAX_LEN: go to DROP.
  - Otherwise: pulse tx_data_fifo_rd to prefetch byte 0, then go to PREAMBLE.
- PREAMBLE: 16 nibble slots with mii_tx_en=1: fifteen 0x5, then 0xD. Then go to DATA.
- DATA: each byte is sent low nibble first, then high nibble.
  - tx_data_fifo_rd pulses on the clk the low nibble is driven, provided further bytes remain.
  - The fetched byte is captured into a holding register on the next clk.
  - Total rd pulses per frame = len; never more.
  - After the high nibble of byte len-1: go to PAD (if compiled in and len<MIN_FRAME), else FCS (if compiled in), else IFG.
- PAD: 0x00 bytes until MIN_FRAME bytes have been sent.
- FCS: 4 bytes, see Optional Feature.
- IFG: mii_tx_en=0, mii_txd=0 for IFG_NIBBLES tx_ce slots.
  - On completion, pulse frame_done and go to IDLE.
  - A new descriptor is not popped before IFG completes.
- DROP: issue len tx_data_fifo_rd pulses, one per tx_ce slot, while mii_tx_en stays 0.
  - Then pulse frame_drop and go to IDLE. No IFG is applied.
- Byte counter is 11 bits with no wrap; the len≤MAX_LEN check guarantees this.
- Reset asserted mid-frame: next clk drives mii_tx_en=0 and state IDLE.
  - The FIFO remainder is not flushed; that is the fabric's responsibility.
- The data FIFO is never empty mid-frame; this is guaranteed by the writer, and no underrun handling exists.

Optional Feature:
- Macro: MII_TX_CRC_GEN_EN.
- Defined:
  - Frames with len<MIN_FRAME are zero-padded to MIN_FRAME.
  - A 4-byte FCS is appended: CRC-32, poly 0x04C11DB7, reflected, init 0xFFFFFFFF, final inversion.
  - The FCS covers data plus pad and is sent LSB byte first, low nibble first.
  - The CRC updates one byte per byte slot, using an 8-bit parallel update.
- Undefined:
  - No PAD and no FCS states; DATA goes directly to IFG.
  - Descriptor length already includes FCS; bytes are sent verbatim.

Test Plan:
- Single frame, len=64, CRC_GEN_EN -> 16 preamble + 136 nibbles (152 total) with mii_tx_en=1; exactly 64 data rd pulses; last 8 nibbles equal the reference-model CRC; then 24 idle slots; frame_done once.
- len=10, CRC_GEN_EN -> 16 + 2*(60+4) = 144 tx_en nibbles; 10 data rd pulses; nibbles for bytes 10..59 are 0.
- len=10, macro undefined -> 16 + 20 = 36 tx_en nibbles; no pad; frame_done after 24 idle slots.
- Descriptor len=0, then len=1600 -> first: no data reads, frame_drop; second: 1600 data reads, mii_tx_en never high, frame_drop.
- Two descriptors queued back-to-back -> second tx_ptr_fifo_rd occurs only after the 24th IFG slot; the gap between tx_en deassert and reassert is exactly 24 tx_ce slots.
- Assert rstn=0 during DATA byte 20 -> next clk: mii_tx_en=0, busy=0, all rd outputs 0.
